// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: glitch-filtered line conditioning, 11-bit frame checking and a
// 32-bit scancode history with the newest byte in [7:0].
module ps2_scancode_rx #(
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [31:0] keycode,
  output logic        keycode_valid,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Odd parity holds when the data bits and the parity bit together carry an odd count of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data_byte, input logic par_bit);
    return (^data_byte) ^ par_bit;
  endfunction

  // Index 0 is ps2_clk, index 1 is ps2_data.
  logic [1:0]          sync1_r;
  logic [1:0]          sync2_r;
  logic [1:0]          filt_r;
  logic [1:0][FW-1:0]  fcnt_r;
  logic                clk_prev_r;
  logic                fall_s;
  logic                data_s;

  state_t              state_r, state_n;
  logic [2:0]          bitcnt_r, bitcnt_n;
  logic [7:0]          shift_r, shift_n;
  logic                par_r, par_n;
  logic [TW-1:0]       tocnt_r, tocnt_n;
  logic [31:0]         keycode_n;
  logic                valid_n;
  logic                err_n;
  logic                timeout_s;

  // Two-flop synchronisers for both raw lines; idle level is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 2'b11;
      sync2_r <= 2'b11;
    end else begin
      sync1_r <= {ps2_data, ps2_clk};
      sync2_r <= sync1_r;
    end
  end

  // Filtered level follows the synced level only after FILTER_CYCLES steady cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_r     <= 2'b11;
      fcnt_r     <= '0;
      clk_prev_r <= 1'b1;
    end else begin
      clk_prev_r <= filt_r[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] == filt_r[i]) begin
          fcnt_r[i] <= '0;
        end else if (fcnt_r[i] == FW'(FILTER_CYCLES - 1)) begin
          filt_r[i] <= sync2_r[i];
          fcnt_r[i] <= '0;
        end else begin
          fcnt_r[i] <= fcnt_r[i] + FW'(1);
        end
      end
    end
  end

  assign fall_s    = clk_prev_r & ~filt_r[0];
  assign data_s    = filt_r[1];
  assign timeout_s = (state_r != IDLE) && (tocnt_r == TW'(TIMEOUT_CYCLES));

  // Frame state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state, datapath and completion-pulse logic; a timeout overrides any coincident fall.
  always_comb begin
    state_n   = state_r;
    bitcnt_n  = bitcnt_r;
    shift_n   = shift_r;
    par_n     = par_r;
    tocnt_n   = tocnt_r;
    keycode_n = keycode;
    valid_n   = 1'b0;
    err_n     = 1'b0;
    if (timeout_s) begin
      state_n  = IDLE;
      bitcnt_n = 3'd0;
      shift_n  = 8'd0;
      tocnt_n  = '0;
      err_n    = 1'b1;
    end else begin
      if ((state_r == IDLE) || fall_s) begin
        tocnt_n = '0;
      end else begin
        tocnt_n = tocnt_r + TW'(1);
      end
      if (fall_s) begin
        case (state_r)
          IDLE: begin
            if (!data_s) begin
              state_n  = DATA;
              bitcnt_n = 3'd0;
            end else begin
              state_n = IDLE;
            end
          end
          DATA: begin
            shift_n  = {data_s, shift_r[7:1]};
            bitcnt_n = bitcnt_r + 3'd1;
            if (bitcnt_r == 3'd7) begin
              state_n = PARITY;
            end else begin
              state_n = DATA;
            end
          end
          PARITY: begin
            par_n   = data_s;
            state_n = STOP;
          end
          STOP: begin
            state_n = IDLE;
            if (data_s && odd_parity_ok(shift_r, par_r)) begin
              keycode_n = {keycode[23:0], shift_r};
              valid_n   = 1'b1;
            end else begin
              err_n = 1'b1;
            end
          end
          default: begin
            state_n = IDLE;
          end
        endcase
      end else begin
        state_n = state_r;
      end
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitcnt_r      <= 3'd0;
      shift_r       <= 8'd0;
      par_r         <= 1'b0;
      tocnt_r       <= '0;
      keycode       <= 32'd0;
      keycode_valid <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      bitcnt_r      <= bitcnt_n;
      shift_r       <= shift_n;
      par_r         <= par_n;
      tocnt_r       <= tocnt_n;
      keycode       <= keycode_n;
      keycode_valid <= valid_n;
      frame_err     <= err_n;
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx; PS/2 bit period shortened to 80 clk so frames fit
// well inside the 2000-cycle simulation timeout.
module tb_ps2_scancode_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [31:0] keycode;
  logic        keycode_valid;
  logic        frame_err;

  int errors = 0;
  int checks = 0;
  int vcnt = 0;
  int ecnt = 0;
  int both = 0;
  int v0, e0;

  ps2_scancode_rx #(.FILTER_CYCLES(8), .TIMEOUT_CYCLES(2000)) dut (
    .clk           (clk),
    .rst           (rst),
    .ps2_clk       (ps2_clk),
    .ps2_data      (ps2_data),
    .keycode       (keycode),
    .keycode_valid (keycode_valid),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  // Pulse monitors, sampled away from the active edge; a 2-cycle pulse counts twice.
  always @(negedge clk) begin
    if (keycode_valid) vcnt++;
    if (frame_err) ecnt++;
    if (keycode_valid && frame_err) both++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Send the first n bits of an 11-bit frame, LSB (start bit) first.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      wait_cyc(20);
      ps2_clk = 1'b0;
      wait_cyc(40);
      ps2_clk = 1'b1;
      wait_cyc(20);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_par);
    logic p;
    p = ~(^b) ^ flip_par;
    send_bits({1'b1, p, b, 1'b0}, 11);
    wait_cyc(10);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(20);
  endtask

  initial begin
    wait_cyc(5);
    check("reset_keycode", keycode, 32'h0);
    check("reset_valid", {31'd0, keycode_valid}, 32'd0);
    check("reset_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    wait_cyc(20);

    // 1: single good frame
    send_frame(8'h6B, 1'b0);
    check("t1_keycode", keycode, 32'h0000006B);
    check("t1_valid_cnt", vcnt, 1);
    check("t1_err_cnt", ecnt, 0);

    // 2: history shifting, starting from a clean reset
    pulse_reset();
    v0 = vcnt;
    send_frame(8'hE0, 1'b0);
    send_frame(8'h74, 1'b0);
    check("t2_two_bytes", keycode, 32'h0000E074);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h74, 1'b0);
    check("t2_keycode", keycode, 32'h74E0F074);
    check("t2_valid_cnt", vcnt - v0, 5);

    // 3: bad parity dropped, next frame accepted
    v0 = vcnt; e0 = ecnt;
    send_frame(8'h75, 1'b1);
    check("t3_err_cnt", ecnt - e0, 1);
    check("t3_no_valid", vcnt - v0, 0);
    check("t3_keycode_held", keycode, 32'h74E0F074);
    send_frame(8'h72, 1'b0);
    check("t3_after_good", keycode, 32'hE0F07472);

    // 4: short glitches while idle must not start a frame
    v0 = vcnt; e0 = ecnt;
    ps2_data = 1'b0;
    wait_cyc(30);
    ps2_clk = 1'b0;
    wait_cyc(5);
    ps2_clk = 1'b1;
    wait_cyc(30);
    ps2_data = 1'b1;
    wait_cyc(30);
    ps2_data = 1'b0;
    wait_cyc(5);
    ps2_data = 1'b1;
    wait_cyc(30);
    check("t4_no_pulses", (vcnt - v0) + (ecnt - e0), 0);
    send_frame(8'h29, 1'b0);
    check("t4_frame_aligned", keycode, 32'hF0747229);
    check("t4_err_cnt", ecnt - e0, 0);

    // 5: stalled frame times out, then receiver recovers
    v0 = vcnt; e0 = ecnt;
    send_bits({1'b1, 1'b0, 8'h0F, 1'b0}, 5);
    wait_cyc(1850);
    check("t5_no_early_timeout", ecnt - e0, 0);
    wait_cyc(250);
    check("t5_timeout_err", ecnt - e0, 1);
    check("t5_keycode_held", keycode, 32'hF0747229);
    send_frame(8'h6B, 1'b0);
    check("t5_recover", {24'd0, keycode[7:0]}, 32'h0000006B);
    check("t5_valid_cnt", vcnt - v0, 1);

    // 6: reset mid-frame, next frame starts clean
    send_bits({1'b1, 1'b0, 8'hAA, 1'b0}, 6);
    pulse_reset();
    check("t6_reset_keycode", keycode, 32'h0);
    v0 = vcnt;
    send_frame(8'h72, 1'b0);
    check("t6_keycode", keycode, 32'h00000072);
    check("t6_valid_cnt", vcnt - v0, 1);

    check("never_both", both, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
